// File: rtl/grf_mp_sb_if.sv
// Port bundle for grf_mp_sb: read lanes, two write ports, issue strobe and
// the init_done status. The master modport drives requests; slave is the GRF.
interface grf_mp_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
);
  logic                init_done;
  logic [NR*AW-1:0]    raddr;
  logic [NR*DW-1:0]    rdata;
  logic [NR-1:0]       rbusy;
  logic                we0;
  logic [AW-1:0]       waddr0;
  logic [DW-1:0]       wdata0;
  logic                we1;
  logic [AW-1:0]       waddr1;
  logic [DW-1:0]       wdata1;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;

  modport master (
    input  init_done, rdata, rbusy,
    output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, iss_en, iss_addr
  );

  modport slave (
    output init_done, rdata, rbusy,
    input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, iss_en, iss_addr
  );
endinterface

// File: rtl/grf_mp_sb.sv
// Multi-port general register file: two write ports (port 1 wins conflicts),
// NR combinational read lanes, per-register busy scoreboard and a sequenced
// clear of every entry after reset. Entry 0 is hardwired to zero.
// Optional feature: define GRF_BYPASS_EN for same-cycle write-to-read bypass.
module grf_mp_sb #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
) (
  input  logic         clk,
  input  logic         rst,
  grf_mp_sb_if.slave   bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  logic              ready;
  logic              wr0_ok, wr1_ok, iss_ok;

  assign ready  = (state_q == READY);
  assign wr0_ok = ready && bus.we0    && (bus.waddr0   != '0);
  assign wr1_ok = ready && bus.we1    && (bus.waddr1   != '0);
  assign iss_ok = ready && bus.iss_en && (bus.iss_addr != '0);

  // State register: reset restarts the clear walk from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk cnt through every entry, leave CLEAR on the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = READY;
    end
  end

  // Outputs of the FSM: init_done is simply "in READY"
  always_comb begin
    bus.init_done = (state_q == READY);
  end

  // Array and scoreboard update; issue is applied last so a new producer
  // supersedes a retiring write to the same register
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q]  <= '0;
        busy_q[cnt_q] <= 1'b0;
      end else begin
        if (wr0_ok) begin
          mem_q[bus.waddr0]  <= bus.wdata0;
          busy_q[bus.waddr0] <= 1'b0;
        end
        if (wr1_ok) begin
          mem_q[bus.waddr1]  <= bus.wdata1;
          busy_q[bus.waddr1] <= 1'b0;
        end
        if (iss_ok) busy_q[bus.iss_addr] <= 1'b1;
      end
    end
  end

  logic [NR-1:0][DW-1:0] rdata_w;
  logic [NR-1:0]         rbusy_w;
  logic [AW-1:0]         ra;

  // Read lanes: zero while clearing or for entry 0, else array (or bypass)
  always_comb begin
    rdata_w = '0;
    rbusy_w = '0;
    ra      = '0;
    for (int i = 0; i < NR; i++) begin
      ra = bus.raddr[i*AW +: AW];
      if (ready && (ra != '0)) begin
        rdata_w[i] = mem_q[ra];
        rbusy_w[i] = busy_q[ra];
`ifdef GRF_BYPASS_EN
        // Younger port checked first so it wins the same-cycle conflict
        if (bus.we1 && (bus.waddr1 == ra)) begin
          rdata_w[i] = bus.wdata1;
          rbusy_w[i] = 1'b0;
        end else if (bus.we0 && (bus.waddr0 == ra)) begin
          rdata_w[i] = bus.wdata0;
          rbusy_w[i] = 1'b0;
        end
`else
        // Without bypass a write is only visible after the edge
`endif
      end
    end
  end

  assign bus.rdata = rdata_w;
  assign bus.rbusy = rbusy_w;
endmodule

// File: tb/tb_grf_mp_sb.sv
// Self-checking bench for grf_mp_sb with four read lanes. Expected read
// results are queued when stimulus is driven and compared when sampled.
module tb_grf_mp_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
`ifdef GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grf_mp_sb_if #(.DW(DW), .AW(AW), .NR(NR)) bus();

  grf_mp_sb #(.DW(DW), .AW(AW), .NR(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string         name;
    int            lane;
    logic [DW-1:0] d;
    logic          b;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic               we0;
    logic [AW-1:0]      wa0;
    logic [DW-1:0]      wd0;
    logic               we1;
    logic [AW-1:0]      wa1;
    logic [DW-1:0]      wd1;
    logic               iss;
    logic [AW-1:0]      ia;
    logic [AW-1:0]      ra [NR];
    logic [DW-1:0]      xd [NR];
    logic               xb [NR];
  } vec_t;
  vec_t vt [7];

  // Reference model of the array, used for same-cycle predictions
  logic [DW-1:0] m  [32];
  logic [31:0]   mb;
  bit            ready_m = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input int lane, input logic [DW-1:0] d, input logic b);
    exp_t e;
    e.name = name; e.lane = lane; e.d = d; e.b = b;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp({e.name, "_data"}, 64'(bus.rdata[e.lane*DW +: DW]), 64'(e.d));
      cmp({e.name, "_busy"}, 64'(bus.rbusy[e.lane]), 64'(e.b));
    end
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.iss_en = 1'b0; bus.iss_addr = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, a1, a2, a3);
    bus.raddr = {a3, a2, a1, a0};
  endtask

  function automatic logic [DW-1:0] pred_d(input logic [AW-1:0] a);
    if (!ready_m || a == '0) return '0;
    if (BYP && bus.we1 && bus.waddr1 == a) return bus.wdata1;
    if (BYP && bus.we0 && bus.waddr0 == a) return bus.wdata0;
    return m[a];
  endfunction

  function automatic logic pred_b(input logic [AW-1:0] a);
    if (!ready_m || a == '0) return 1'b0;
    if (BYP && ((bus.we1 && bus.waddr1 == a) || (bus.we0 && bus.waddr0 == a))) return 1'b0;
    return mb[a];
  endfunction

  task automatic push_pred(input string name);
    for (int i = 0; i < NR; i++)
      push(name, i, pred_d(bus.raddr[i*AW +: AW]), pred_b(bus.raddr[i*AW +: AW]));
  endtask

  task automatic model_zero();
    for (int i = 0; i < 32; i++) m[i] = '0;
    mb = '0;
  endtask

  // Apply current inputs to the model, then advance to the next negedge
  task automatic step();
    if (ready_m) begin
      if (bus.we0 && bus.waddr0 != '0) begin m[bus.waddr0] = bus.wdata0; mb[bus.waddr0] = 1'b0; end
      if (bus.we1 && bus.waddr1 != '0) begin m[bus.waddr1] = bus.wdata1; mb[bus.waddr1] = 1'b0; end
      if (bus.iss_en && bus.iss_addr != '0) mb[bus.iss_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    idle();
    rst = 1'b1;
    ready_m = 1'b0;
    model_zero();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Count edges after reset release; junk=1 attempts writes/issues mid-clear
  task automatic run_clear(input int edges, input bit junk);
    set_ra(5'd1, 5'd2, 5'd3, 5'd4);
    for (int k = 1; k <= edges; k++) begin
      @(negedge clk);
      #1;
      cmp($sformatf("init_done_e%0d", k), 64'(bus.init_done), 64'(k == 32));
      if (k == 32) ready_m = 1'b1;
      push_pred($sformatf("clr_rd_e%0d", k));
      drain();
      if (junk && k <= 30) begin
        bus.we0 = 1'b1; bus.waddr0 = 5'd2; bus.wdata0 = 32'h0000_0BAD;
        bus.we1 = 1'b1; bus.waddr1 = 5'd4; bus.wdata1 = 32'h0000_0BAD;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
      end else begin
        idle();
      end
    end
  endtask

  function automatic vec_t mk(
    input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic is, input logic [AW-1:0] ia,
    input logic [AW-1:0] r0, r1, r2, r3,
    input logic [DW-1:0] x0, x1, x2, x3,
    input logic b0, b1, b2, b3);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.iss = is; v.ia = ia;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
    v.xd[0] = x0; v.xd[1] = x1; v.xd[2] = x2; v.xd[3] = x3;
    v.xb[0] = b0; v.xb[1] = b1; v.xb[2] = b2; v.xb[3] = b3;
    return v;
  endfunction

  initial begin
    // Vectors start from a freshly cleared array; expectations are for the cycle after
    vt[0] = mk(1, 3, 32'h1003, 1, 4, 32'h2004, 0, 0,  3, 4, 0, 1,  32'h1003, 32'h2004, 0, 0,  0, 0, 0, 0);
    vt[1] = mk(0, 0, 0, 0, 0, 0, 1, 3,                3, 4, 3, 2,  32'h1003, 32'h2004, 32'h1003, 0,  1, 0, 1, 0);
    vt[2] = mk(0, 0, 0, 1, 3, 32'h3333, 0, 0,         3, 3, 4, 0,  32'h3333, 32'h3333, 32'h2004, 0,  0, 0, 0, 0);
    vt[3] = mk(1, 5, 32'h11, 1, 5, 32'h22, 0, 0,      5, 5, 5, 5,  32'h22, 32'h22, 32'h22, 32'h22,  0, 0, 0, 0);
    vt[4] = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0,    0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    vt[5] = mk(0, 0, 0, 1, 6, 32'h66, 1, 6,           6, 6, 5, 3,  32'h66, 32'h66, 32'h22, 32'h3333,  1, 1, 0, 0);
    vt[6] = mk(1, 6, 32'h60, 1, 7, 32'h70, 0, 0,      6, 7, 5, 3,  32'h60, 32'h70, 32'h22, 32'h3333,  0, 0, 0, 0);

    idle();
    model_zero();
    set_ra(5'd1, 5'd2, 5'd3, 5'd4);
    rst = 1'b1;
    @(negedge clk);
    #1;
    cmp("reset_init_done", 64'(bus.init_done), 64'd0);
    rst = 1'b0;
    run_clear(32, 1'b0);

    // Fill entries 1..4 with a marker, then show a fresh reset wipes them
    for (int a = 1; a <= 4; a++) begin
      bus.we0 = 1'b1; bus.waddr0 = AW'(a); bus.wdata0 = 32'hDEAD_BEEF;
      step();
    end
    idle();
    #1;
    for (int i = 0; i < NR; i++) push("deadbeef", i, 32'hDEAD_BEEF, 1'b0);
    drain();
    pulse_rst();
    run_clear(32, 1'b0);

    // Table-driven vectors: same-cycle check against model, next cycle against table
    for (int v = 0; v < 7; v++) begin
      bus.we0 = vt[v].we0; bus.waddr0 = vt[v].wa0; bus.wdata0 = vt[v].wd0;
      bus.we1 = vt[v].we1; bus.waddr1 = vt[v].wa1; bus.wdata1 = vt[v].wd1;
      bus.iss_en = vt[v].iss; bus.iss_addr = vt[v].ia;
      set_ra(vt[v].ra[0], vt[v].ra[1], vt[v].ra[2], vt[v].ra[3]);
      #1;
      push_pred($sformatf("vec%0d_same", v));
      drain();
      step();
      idle();
      #1;
      for (int i = 0; i < NR; i++) push($sformatf("vec%0d_next", v), i, vt[v].xd[i], vt[v].xb[i]);
      drain();
    end

    // Scoreboard set/clear race on register 7 (holds 0x70)
    set_ra(5'd7, 5'd7, 5'd7, 5'd7);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    #1;
    push("race_t0", 0, 32'h70, 1'b0);
    drain();
    step(); idle(); #1;
    push("race_t1", 1, 32'h70, 1'b1);
    drain();
    step();
    step();
    bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h5A;
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    step(); idle(); #1;
    push("race_t4", 2, 32'h5A, 1'b1);
    drain();
    step();
    bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h5B;
    #1;
    push("race_t5", 3, BYP ? 32'h5B : 32'h5A, BYP ? 1'b0 : 1'b1);
    drain();
    step(); idle(); #1;
    push("race_t6", 0, 32'h5B, 1'b0);
    drain();

    // All four lanes on one register while port 1 overwrites it
    set_ra(5'd9, 5'd9, 5'd9, 5'd9);
    bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h99;
    step(); idle();
    bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h77;
    #1;
    for (int i = 0; i < NR; i++) push("mport_same", i, BYP ? 32'h77 : 32'h99, 1'b0);
    drain();
    step(); idle(); #1;
    for (int i = 0; i < NR; i++) push("mport_next", i, 32'h77, 1'b0);
    drain();

    // Reset mid-clear at edge 10, with junk traffic during the restarted walk
    pulse_rst();
    run_clear(9, 1'b0);
    pulse_rst();
    run_clear(32, 1'b1);
    set_ra(5'd2, 5'd3, 5'd4, 5'd9);
    #1;
    for (int i = 0; i < NR; i++) push("abort_after", i, 32'h0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/grf_mp_sb.md
# grf_mp_sb

Parametrised multi-port general register file with two write ports, N combinational read ports, a per-register busy scoreboard and a sequenced multi-cycle clear after reset. It replaces the single-write/two-read GRF in the pipeline's decode stage. The scoreboard lets the hazard unit stall on a pending producer instead of decoding forwarding paths per stage.

## Interface
- DW, 32, data width in bits
- AW, 5, address width; DEPTH = 2**AW entries
- NR, 2, number of read ports (1..8)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- init_done  out  1  high once the clear sequence completes; reset value 0
- raddr  in  NR*AW  read addresses, port i at bits [i*AW +: AW]
- rdata  out  NR*DW  read data, port i at bits [i*DW +: DW]; combinational
- rbusy  out  NR  scoreboard bit for each read address; combinational
- we0  in  1  write enable, port 0 (older instruction)
- waddr0  in  AW  write address, port 0
- wdata0  in  DW  write data, port 0
- we1  in  1  write enable, port 1 (younger instruction; wins conflicts)
- waddr1  in  AW  write address, port 1
- wdata1  in  DW  write data, port 1
- iss_en  in  1  issue strobe: marks iss_addr busy
- iss_addr  in  AW  destination register of the issuing instruction

## Operation
- States are CLEAR and READY. Any cycle with rst=1 sets state to CLEAR and cnt to 0. No array write happens in that cycle.
- CLEAR, rst=0: each edge sets mem[cnt]=0 and busy[cnt]=0, then increments cnt. At cnt==DEPTH-1 that edge also enters READY and sets init_done=1.
- In CLEAR: we0, we1 and iss_en are ignored; every rdata lane reads 0; every rbusy bit reads 0.
- Entry 0 is hardwired to zero:
  - writes to address 0 are dropped;
  - busy[0] is never set;
  - reads of address 0 return 0 with rbusy=0.
- Write (READY): weK && waddrK!=0 writes wdataK to mem[waddrK] and clears busy[waddrK].
  - When waddr0==waddr1, both enabled, mem takes wdata1.
- Issue (READY): iss_en && iss_addr!=0 sets busy[iss_addr].
  - When a write and an issue target the same address in the same cycle, the set wins (a new producer supersedes the retiring one).
- Read lane i, address a: rdata = mem[a], rbusy = busy[a], subject to the bypass rules under Configuration.
- Reads are fully independent per port. Any number of ports may share one address.

## Timing
- Write-to-read latency: 1 edge through the array, or 0 cycles with the bypass compiled in.
- Issue-to-rbusy latency: 1 edge. There is no same-cycle bypass of iss_en.
- init_done rises on the DEPTH-th rising edge after rst deasserts (edge 32 for AW=5). It stays high until the next rst.
- rst asserted mid-clear or in READY aborts immediately. The next sequence restarts at cnt=0 and takes a full DEPTH cycles.
- cnt is AW bits wide and never wraps in normal use. The transition to READY happens at DEPTH-1.

## Configuration
- GRF_BYPASS_EN defined (same-cycle bypass, applies only when READY and a≠0):
  - If we1 && waddr1==a: rdata=wdata1, rbusy=0.
  - Else if we0 && waddr0==a: rdata=wdata0, rbusy=0.
  - Else: array value and stored busy bit.
  - iss_en does not affect the bypass.
- GRF_BYPASS_EN undefined:
  - rdata comes from the array only and rbusy is the stored bit.
  - Writes become visible one cycle later. The pipeline must stall one extra cycle.

## Test plan
- Clear sequence: pulse rst for 1 cycle, then hold rst=0. Required: init_done=0 for edges 1-31 and goes 1 at edge 32. Every read returns 0 with rbusy=0, including lanes whose entries held 0xDEADBEEF before reset.
- Dual-write conflict: we0=we1=1, waddr0=waddr1=5, wdata0=0x11, wdata1=0x22. Required: the next cycle raddr=5 reads 0x22. With GRF_BYPASS_EN, the same cycle also reads 0x22.
- Register zero: we0=1, waddr0=0, wdata0=0xFFFF_FFFF, iss_en=1, iss_addr=0. Required: rdata=0 and rbusy=0 on every port, in the same cycle and the next.
- Scoreboard set/clear race: iss_en with iss_addr=7 at cycle t sets rbusy=1 at t+1. At t+3, we0 (waddr0=7, data 0x5A) and iss_en (addr 7) together. Required: at t+4 rbusy=1 and rdata=0x5A. A lone write at t+5 gives rbusy=0 at t+6.
- Reset mid-clear: assert rst at edge 10 of the clear sequence for 1 cycle. Required: init_done stays 0, rises exactly 32 edges after the deassertion, and writes attempted in between are dropped.
- Multi-port read (NR=4): all four lanes address 9 while we1 writes 0x77 to 9. Required: all four lanes return 0x77 in the same cycle with bypass enabled, and the old value without it.
